// File: rtl/nn_stream_decoder_if.sv
// Handshake and stream bundle for nn_stream_decoder.
// The master drives the stream and READY. The slave (the decoder) returns the windowed count.
interface nn_stream_decoder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic           EN;
    logic           IN;
    logic           READY;
    logic [WIDTH:0] VALUE;
    logic           VALID;
    logic           OVERRUN;

    modport master (
        output EN, IN, READY,
        input  VALUE, VALID, OVERRUN
    );

    modport slave (
        input  EN, IN, READY,
        output VALUE, VALID, OVERRUN
    );
endinterface

// File: rtl/nn_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WIDTH enabled samples, valid/ready output.
// Optional sticky overrun detection is enabled by defining NN_STREAM_DECODER_OVERRUN_EN.
module nn_stream_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 CLK,
    input logic                 INIT,
    nn_stream_decoder_if.slave  bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sc_q, sc_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   value_q, value_d;
    logic [WIDTH:0]   acc_sum;
    logic             win_close;

    assign win_close = bus.EN && (sc_q == {WIDTH{1'b1}});
    // The sample taken at window close is included in the reported count.
    assign acc_sum   = acc_q + {{WIDTH{1'b0}}, bus.IN};

    always_comb begin
        sc_d    = sc_q;
        acc_d   = acc_q;
        value_d = value_q;
        if (bus.EN) begin
            sc_d = sc_q + 1'b1;
            if (win_close) begin
                acc_d   = '0;
                value_d = acc_sum;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (win_close) state_d = StFull;
            StFull:  if (!win_close && bus.READY) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q <= StEmpty;
            sc_q    <= '0;
            acc_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            acc_q   <= acc_d;
            value_q <= value_d;
        end
    end

    assign bus.VALUE = value_q;
    assign bus.VALID = (state_q == StFull);

`ifdef NN_STREAM_DECODER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // A close with the consumer stalled overwrites an unread result.
    always_comb begin
        overrun_d = overrun_q | (win_close && (state_q == StFull) && !bus.READY);
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.OVERRUN = overrun_q;
`else
    assign bus.OVERRUN = 1'b0;
`endif
endmodule

// File: doc/nn_stream_decoder.md
# nn_stream_decoder

Stochastic-to-binary decoder for the stochastic neural network datapath. It is the receiving end of the node output bitstream: it consumes a unipolar stochastic stream and counts ones over a fixed window of 2^WIDTH enabled samples. It presents each window's count as a binary value through a valid/ready output register. It sits after a node's burst stage, either at the network outputs or where a controller or training logic needs a binary estimate of an activation.

## Interface

- WIDTH, 8, log2 of window length; window = 2^WIDTH enabled samples.
- CLK  input  1  system clock; all state updates on rising edge.
- INIT  input  1  reset, synchronous and active-high.
- EN  input  1  sample strobe; IN is counted only in cycles with EN=1.
- IN  input  1  stochastic bitstream, one bit per cycle.
- VALUE  output  WIDTH+1  count of ones in the last completed window, range 0..2^WIDTH.
- VALID  output  1  VALUE holds an unconsumed result.
- READY  input  1  consumer accepts VALUE when VALID=1 and READY=1 at a rising edge.
- OVERRUN  output  1  sticky flag: a result was overwritten before it was consumed.

## Operation

- Internal state:
  - sample counter SC, WIDTH bits.
  - accumulator ACC, WIDTH+1 bits.
  - output register VALUE/VALID.
  - OVERRUN flag.
- Accumulate on every cycle with EN=1:
  - ACC <= ACC + IN.
  - SC <= SC + 1, wrapping at 2^WIDTH.
- Window close: the cycle with EN=1 and SC = 2^WIDTH-1.
  - VALUE <= ACC + IN.
  - VALID <= 1.
  - ACC <= 0 and SC <= 0 (SC wraps).
  - Accumulation continues on the next cycle with no dead cycle, so no sample is lost between windows.
- EN=0: SC and ACC hold; IN is ignored.
- Handshake:
  - With VALID=1 and READY=1 and no window close in the same cycle, VALID <= 0.
  - VALUE holds its last value after consumption.
- Window close while VALID=1 and READY=0:
  - VALUE is overwritten with the new count and VALID stays 1.
  - OVERRUN is set (see Configuration).
- Window close in the same cycle as a handshake (VALID=1, READY=1):
  - The old value is consumed and the new value is loaded.
  - VALID stays 1; this is not an overrun.
- READY is ignored while VALID=0.
- Arithmetic: ACC cannot overflow; its maximum is 2^WIDTH, which fits in WIDTH+1 bits.
- State machine, two states derived from VALID:
  - EMPTY → FULL on window close.
  - FULL → EMPTY on handshake without window close.
  - FULL → FULL on window close, with or without handshake.
- INIT overrides everything, including a window close or handshake in the same cycle.

## Timing

- Reset values, in the cycle after INIT=1: VALUE=0, VALID=0, OVERRUN=0, SC=0, ACC=0.
- Reset mid-window discards the partial count; the next window starts with the first EN=1 cycle after INIT deasserts.
- Latency: VALUE and VALID update on the clock edge that samples the last bit of the window. They are visible 1 cycle after that bit was presented.
- Throughput: one result per 2^WIDTH enabled cycles. With EN tied high, results arrive every 2^WIDTH cycles.
- VALUE is stable while VALID=1, except on an overwrite at window close.
- All outputs are registered; there is no combinational path from IN or READY to any output.

## Configuration

- Macro: NN_STREAM_DECODER_OVERRUN_EN.
- Defined: OVERRUN sets on a window close that occurs with VALID=1 and READY=0. It stays set until INIT.
- Not defined: the overrun logic is removed and OVERRUN is tied to 0. The port is kept so the interface is identical in both builds; overwrite behaviour is unchanged.

## Test plan

- WIDTH=4, INIT then EN=1, IN=1 for 16 cycles, READY=1 → VALID=1 with VALUE=16 one cycle after the 16th sample; VALID drops the following cycle.
- WIDTH=4, EN=1, IN pattern 1010… for 32 cycles, READY=1 → two results, both VALUE=8, 16 cycles apart, no gap cycle.
- WIDTH=4, EN toggled 1/0 every cycle, IN=1 → result VALUE=16 after 32 cycles; IN during EN=0 cycles has no effect.
- WIDTH=4, READY=0, IN=1 for 16 cycles then IN=0 for 16 cycles:
  - after 16 cycles, VALUE=16 and VALID=1;
  - after 32 cycles, VALUE=0 and VALID=1;
  - OVERRUN=1 with the macro defined, OVERRUN=0 without it.
- WIDTH=4, READY pulsed exactly in the window-close cycle of the second window → VALUE=second count, VALID remains 1, OVERRUN=0.
- INIT asserted after 10 samples of IN=1, then 16 samples of IN=0 → VALID=0 immediately after INIT; the next result is VALUE=0, with no residue from the partial window.
